// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, divisor limits and 8N1 frame shape.
// Used by both the receive and transmit sides.
package uart_pkg;

    localparam int DEF_DIV_WIDTH = 16;
    localparam int MIN_DIV       = 4;

    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RST_VAL sets the value both flops take while reset is asserted.
module rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q <= RST_VAL;
            o_q    <= RST_VAL;
        end else begin
            meta_q <= i_d;
            o_q    <= meta_q;
        end
    end

endmodule

// File: rtl/uart_rx_port.sv
// Single-channel 8N1 UART receiver with a one-byte holding register and read handshake.
// Framing errors pulse for one cycle; a byte dropped on a full holding register sets a sticky overrun flag.
module uart_rx_port #(
    parameter int DIV_WIDTH = uart_pkg::DEF_DIV_WIDTH,
    parameter int MIN_DIV   = uart_pkg::MIN_DIV
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    input  logic [DIV_WIDTH-1:0] i_baud_div,
    input  logic                 i_read,
    output logic                 o_ready,
    output logic [7:0]           o_D,
    output logic                 o_frame_err,
    output logic                 o_overrun
);

    import uart_pkg::*;

    localparam logic [DIV_WIDTH-1:0] MIN_DIV_V = DIV_WIDTH'(MIN_DIV);
    localparam logic [2:0]           LAST_BIT  = 3'(DATA_BITS - 1);

    logic rx_s;

    rx_sync #(
        .RST_VAL(1'b1)
    ) u_rx_sync (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_d  (i_rx),
        .o_q  (rx_s)
    );

    rx_state_t            state_q,   state_d;
    logic [DIV_WIDTH-1:0] cnt_q,     cnt_d;
    logic [DIV_WIDTH-1:0] div_q,     div_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shift_q,   shift_d;
    logic [7:0]           data_q,    data_d;
    logic                 ready_q,   ready_d;
    logic                 ferr_q,    ferr_d;
    logic                 ovr_q,     ovr_d;
    logic                 rx_p_q,    rx_p_d;

    logic                 tick;
    logic [DIV_WIDTH-1:0] div_eff;

    assign tick    = (cnt_q == '0);
    assign div_eff = (i_baud_div < MIN_DIV_V) ? MIN_DIV_V : i_baud_div;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        ready_d   = ready_q;
        ferr_d    = 1'b0;
        ovr_d     = ovr_q;
        rx_p_d    = rx_s;

        if (i_read && ready_q) begin
            ready_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Only a true falling edge starts a frame; a line held low cannot retrigger.
                if (rx_p_q && !rx_s) begin
                    div_d   = div_eff;
                    cnt_d   = div_eff >> 1;
                    state_d = START;
                end
            end

            START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d     = div_q - 1'b1;
                        bit_idx_d = '0;
                        state_d   = DATA;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DATA: begin
                if (tick) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    cnt_d     = div_q - 1'b1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    if (!rx_s) begin
                        ferr_d = 1'b1;
                    end else if (!ready_q || i_read) begin
                        // A same-cycle read frees the register, so the new byte replaces the old one.
                        data_d  = shift_q;
                        ready_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            rx_p_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            rx_p_q    <= rx_p_d;
        end
    end

    assign o_ready     = ready_q;
    assign o_D         = data_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_port.sv
// Self-checking bench for uart_rx_port: a frame-level model of the holding register
// and flags is compared every cycle, plus literal expectations for each directed scenario.
module tb_uart_rx_port;

    import uart_pkg::*;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          rd;
    logic [DW-1:0] baud;
    logic          ready;
    logic [7:0]    d;
    logic          ferr;
    logic          ovr;

    uart_rx_port #(
        .DIV_WIDTH(DW),
        .MIN_DIV  (MIN_DIV)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rx       (rx),
        .i_baud_div (baud),
        .i_read     (rd),
        .o_ready    (ready),
        .o_D        (d),
        .o_frame_err(ferr),
        .o_overrun  (ovr)
    );

    // Posedge n happens at time 10n+5; the negedge just before it at 10n.
    always #5 clk = ~clk;

    typedef struct {
        longint     at_edge;
        logic [7:0] data;
        logic       good;
    } ev_t;

    ev_t        ev_q[$];
    int         total = 0;
    int         bad   = 0;
    logic       m_ready = 1'b0;
    logic [7:0] m_d     = 8'h00;
    logic       m_ferr  = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       old_ready;
    bit         cmp_en  = 1'b0;
    int         ferr_seen = 0;

    function automatic longint now_edge();
        return longint'($time / 10);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: each frame ends in one stop-sample event at a known edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready = 1'b0;
            m_d     = 8'h00;
            m_ferr  = 1'b0;
            m_ovr   = 1'b0;
            ev_q.delete();
        end else begin
            old_ready = m_ready;
            m_ferr    = 1'b0;
            if (rd && m_ready) m_ready = 1'b0;
            if (ev_q.size() > 0 && ev_q[0].at_edge == now_edge()) begin
                if (!ev_q[0].good) begin
                    m_ferr = 1'b1;
                end else if (!old_ready || rd) begin
                    m_d     = ev_q[0].data;
                    m_ready = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
                void'(ev_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ready", 32'(ready), 32'(m_ready));
            check("data", 32'(d), 32'(m_d));
            check("frame_err", 32'(ferr), 32'(m_ferr));
            check("overrun", 32'(ovr), 32'(m_ovr));
            if (ferr) ferr_seen++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; stop sample lands mid stop bit plus synchroniser/detect latency.
    task automatic send_frame(input logic [7:0] data, input logic stop, input int baud_in);
        int  dv;
        ev_t e;
        baud      = baud_in[DW-1:0];
        dv        = (baud_in < MIN_DIV) ? MIN_DIV : baud_in;
        e.at_edge = now_edge() + 3 + dv / 2 + (FRAME_BITS - 1) * dv;
        e.data    = data;
        e.good    = stop;
        ev_q.push_back(e);
        rx = 1'b0;
        idle(dv);
        for (int i = 0; i < DATA_BITS; i++) begin
            rx = data[i];
            idle(dv);
        end
        rx = stop;
        idle(dv);
        rx = 1'b1;
    endtask

    task automatic pulse_read();
        rd = 1'b1;
        idle(1);
        rd = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        rx  = 1'b1;
        rd  = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(2);
    endtask

    initial begin
        int     n;
        longint kb;
        longint target;
        int     fbase;

        rst  = 1'b1;
        rx   = 1'b1;
        rd   = 1'b0;
        baud = 16'd16;
        idle(3);
        cmp_en = 1'b1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_data", 32'(d), 32'h00);
        check("rst_flags", {30'd0, ferr, ovr}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Single frame 0xA5 at 16 clocks/bit, with latency measured from the start edge.
        n = 0;
        fork
            send_frame(8'hA5, 1'b1, 16);
            begin
                while (!ready && n < 400) begin
                    idle(1);
                    n++;
                end
            end
        join
        check("latency_a5", n, 156);
        check("data_a5", 32'(d), 32'hA5);
        check("flags_a5", {30'd0, ferr, ovr}, 32'd0);
        pulse_read();
        check("ready_after_read", 32'(ready), 32'd0);
        pulse_read();
        check("read_when_empty", {23'd0, ready, d}, 32'h0A5);

        // Back-to-back frames, no read: second byte is dropped.
        do_reset();
        send_frame(8'h3C, 1'b1, 16);
        send_frame(8'hC3, 1'b1, 16);
        idle(5);
        check("ovr_data", 32'(d), 32'h3C);
        check("ovr_flag", 32'(ovr), 32'd1);
        check("ovr_ready", 32'(ready), 32'd1);

        // Same pair with a read on the second stop sample: replacement, no overrun.
        do_reset();
        kb     = now_edge();
        target = kb + 10 * 16 + 3 + 8 + 9 * 16;
        fork
            begin
                send_frame(8'h3C, 1'b1, 16);
                send_frame(8'hC3, 1'b1, 16);
            end
            begin
                while (now_edge() < target) idle(1);
                pulse_read();
            end
        join
        idle(3);
        check("swap_data", 32'(d), 32'hC3);
        check("swap_ready", 32'(ready), 32'd1);
        check("swap_ovr", 32'(ovr), 32'd0);
        pulse_read();

        // Stop bit low: one-cycle frame error, byte discarded, then recovery.
        fbase = ferr_seen;
        send_frame(8'h55, 1'b0, 16);
        idle(20);
        check("ferr_pulses", ferr_seen - fbase, 1);
        check("ferr_ready", 32'(ready), 32'd0);
        send_frame(8'h12, 1'b1, 16);
        idle(4);
        check("recover_data", 32'(d), 32'h12);
        check("recover_ready", 32'(ready), 32'd1);
        pulse_read();

        // Three-cycle glitch on an idle line is rejected silently.
        fbase = ferr_seen;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(40);
        check("glitch_ready", 32'(ready), 32'd0);
        check("glitch_ferr", ferr_seen - fbase, 0);
        check("glitch_data", 32'(d), 32'h12);

        // Divisor 1 is clamped to the minimum of 4 clocks per bit.
        send_frame(8'h96, 1'b1, 1);
        idle(4);
        check("clamp_data", 32'(d), 32'h96);
        check("clamp_ready", 32'(ready), 32'd1);
        pulse_read();

        // Reset in the middle of the data bits: immediate clear, fresh frame afterwards.
        baud = 16'd16;
        rx   = 1'b0;
        idle(60);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(ready), 32'd0);
        check("midrst_data", 32'(d), 32'h00);
        check("midrst_flags", {30'd0, ferr, ovr}, 32'd0);
        idle(1);
        rx = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(3);
        send_frame(8'h5A, 1'b1, 16);
        idle(4);
        check("post_rst_data", 32'(d), 32'h5A);
        check("post_rst_ready", 32'(ready), 32'd1);

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
